// File: rtl/collision_scan_ctrl.sv
// collision_scan_ctrl: time-shares one collision checker across the car table and collects a per-car hit mask.
// Define COLLISION_SCAN_EARLY_EXIT_EN to end a scan at the first reported collision.
module collision_scan_ctrl #(
    parameter int NUM_CARS  = 10,
    parameter int CHECK_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  wr_index,
    input  logic [9:0]  wr_x,
    input  logic [9:0]  wr_y,
    input  logic [1:0]  wr_orient,
    input  logic        wr_valid,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] hit_mask,
    output logic        any_hit,
    output logic [9:0]  carX,
    output logic [9:0]  carY,
    output logic [1:0]  carOrient,
    output logic [3:0]  carIndex,
    input  logic        collision
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d, done_q, done_d, any_hit_q, any_hit_d;
    logic [15:0] hit_mask_q, hit_mask_d;
    logic [9:0]  car_x_q, car_x_d, car_y_q, car_y_d;
    logic [1:0]  car_orient_q, car_orient_d;
    logic [3:0]  car_index_q, car_index_d;
    logic [9:0]  tab_x_q [NUM_CARS], tab_x_d [NUM_CARS];
    logic [9:0]  tab_y_q [NUM_CARS], tab_y_d [NUM_CARS];
    logic [1:0]  tab_orient_q [NUM_CARS], tab_orient_d [NUM_CARS];
    logic        tab_valid_q [NUM_CARS], tab_valid_d [NUM_CARS];
    logic        sel_valid, last, fin;
    logic [9:0]  sel_x, sel_y;
    logic [1:0]  sel_orient;

    always_comb begin
        sel_valid  = 1'b0;
        sel_x      = '0;
        sel_y      = '0;
        sel_orient = '0;
        for (int i = 0; i < NUM_CARS; i++) begin
            if (idx_q == 4'(i)) begin
                sel_valid  = tab_valid_q[i];
                sel_x      = tab_x_q[i];
                sel_y      = tab_y_q[i];
                sel_orient = tab_orient_q[i];
            end
        end
        last = idx_q == 4'(NUM_CARS - 1);
`ifdef COLLISION_SCAN_EARLY_EXIT_EN
        fin = last || collision;
`else
        fin = last;
`endif
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        hit_mask_d   = hit_mask_q;
        any_hit_d    = any_hit_q;
        car_x_d      = car_x_q;
        car_y_d      = car_y_q;
        car_orient_d = car_orient_q;
        car_index_d  = car_index_q;
        tab_x_d      = tab_x_q;
        tab_y_d      = tab_y_q;
        tab_orient_d = tab_orient_q;
        tab_valid_d  = tab_valid_q;
        case (state_q)
            IDLE: begin
                for (int i = 0; i < NUM_CARS; i++) begin
                    if (wr_en && wr_index == 4'(i)) begin
                        tab_x_d[i]      = wr_x;
                        tab_y_d[i]      = wr_y;
                        tab_orient_d[i] = wr_orient;
                        tab_valid_d[i]  = wr_valid;
                    end
                end
                if (start) begin
                    state_d    = ISSUE;
                    idx_d      = '0;
                    hit_mask_d = '0;
                    any_hit_d  = 1'b0;
                end
            end
            ISSUE: begin
                if (sel_valid) begin
                    car_x_d      = sel_x;
                    car_y_d      = sel_y;
                    car_orient_d = sel_orient;
                    car_index_d  = idx_q;
                    cnt_d        = '0;
                    state_d      = WAIT;
                end else begin
                    state_d = last ? DONE : ISSUE;
                    idx_d   = last ? idx_q : idx_q + 4'd1;
                end
            end
            WAIT: begin
                // The checker result for this car is only trustworthy on the last WAIT edge.
                if (cnt_q == 3'(CHECK_LAT)) begin
                    hit_mask_d = hit_mask_q | (16'(collision) << idx_q);
                    any_hit_d  = any_hit_q | collision;
                    state_d    = fin ? DONE : ISSUE;
                    idx_d      = fin ? idx_q : idx_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hit_mask_q   <= '0;
            any_hit_q    <= 1'b0;
            car_x_q      <= '0;
            car_y_q      <= '0;
            car_orient_q <= '0;
            car_index_q  <= '0;
            for (int i = 0; i < NUM_CARS; i++) begin
                tab_x_q[i]      <= '0;
                tab_y_q[i]      <= '0;
                tab_orient_q[i] <= '0;
                tab_valid_q[i]  <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            hit_mask_q   <= hit_mask_d;
            any_hit_q    <= any_hit_d;
            car_x_q      <= car_x_d;
            car_y_q      <= car_y_d;
            car_orient_q <= car_orient_d;
            car_index_q  <= car_index_d;
            tab_x_q      <= tab_x_d;
            tab_y_q      <= tab_y_d;
            tab_orient_q <= tab_orient_d;
            tab_valid_q  <= tab_valid_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign hit_mask  = hit_mask_q;
    assign any_hit   = any_hit_q;
    assign carX      = car_x_q;
    assign carY      = car_y_q;
    assign carOrient = car_orient_q;
    assign carIndex  = car_index_q;
endmodule

// File: doc/collision_scan_ctrl.md
# collision_scan_ctrl

Sequencer that owns the car table and time-shares the single `collision_detection` checker across every car. On `start` it walks car indices 0..NUM_CARS-1 and presents each active car's position, orientation and index to the checker. It samples `collision` after the checker's fixed latency and accumulates a per-car hit mask. It sits between game logic (table writes, scan requests) and `collision_detection`.

## Interface
Parameters:
- NUM_CARS, 10, number of table entries scanned; legal range 1..16.
- CHECK_LAT, 1, registered latency of `collision_detection` in clock edges; legal range 1..7.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  write the table entry selected by wr_index.
- wr_index  in  4  entry to write; values >= NUM_CARS are ignored.
- wr_x  in  10  car X position.
- wr_y  in  10  car Y position.
- wr_orient  in  2  car orientation.
- wr_valid  in  1  entry active flag; 0 removes the car from scans.
- start  in  1  scan request, sampled only in IDLE.
- busy  out  1  high from the start-accept edge until DONE exits.
- done  out  1  one-cycle pulse at scan end.
- hit_mask  out  16  bit i = car i collided in the last scan; bits >= NUM_CARS always 0.
- any_hit  out  1  OR of hit_mask.
- carX  out  10  to checker, registered.
- carY  out  10  to checker, registered.
- carOrient  out  2  to checker, registered.
- carIndex  out  4  to checker, registered.
- collision  in  1  from checker.

## Operation
- Table: NUM_CARS entries of {x, y, orient, valid}. Reset clears every valid bit; x, y and orient reset to 0.
- Writes:
  - Accepted only in IDLE. A write with busy=1 is dropped silently.
  - A write and start in the same IDLE cycle: the write lands and the scan uses the new value.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - start=1 → ISSUE with idx=0; hit_mask and any_hit clear to 0; busy goes to 1.
  - start while busy is ignored.
- ISSUE, entry idx:
  - Valid entry: load carX, carY, carOrient and carIndex (carIndex = idx), clear the wait counter, go to WAIT.
  - Invalid entry: outputs unchanged, mask bit stays 0. If idx = NUM_CARS-1 go to DONE, else increment idx and stay in ISSUE.
- WAIT:
  - Lasts CHECK_LAT+1 cycles.
  - On the final WAIT edge, sample `collision` into hit_mask[idx].
  - Then, if idx = NUM_CARS-1, go to DONE; else increment idx and go to ISSUE.
- DONE: done=1 for one cycle, then IDLE, where busy=0.
- hit_mask and any_hit hold their values from the end of a scan until the next accepted start.
- any_hit updates in the same cycle as the mask bit.
- idx is a 4-bit counter; it never wraps past NUM_CARS-1.
- Reset mid-scan: next state is IDLE, all outputs return to reset values, and no done pulse is produced.

## Timing
- Reset values: busy=0, done=0, hit_mask=0, any_hit=0, carX=0, carY=0, carOrient=0, carIndex=0.
- Start-accept edge S: busy=1 after S.
- An active car costs CHECK_LAT+2 cycles; an inactive car costs 1 cycle.
- The sample edge comes CHECK_LAT+1 edges after the edge that loaded the checker inputs.
- done is high in the cycle after edge S + (active×(CHECK_LAT+2) + inactive×1).
- busy drops one cycle after done.
- Checker inputs change only on ISSUE edges for active entries; they hold their last value in IDLE.

## Configuration
- COLLISION_SCAN_EARLY_EXIT_EN defined: the first sample with collision=1 sets its hit_mask bit and goes straight to DONE. The remaining entries are not scanned, so the mask has at most one bit set.
- Not defined: every entry is always scanned and all colliding cars are reported.

## Test plan
- Reset, then wait 5 cycles → busy=0, done=0, hit_mask=0, carX/carY/carIndex=0. Start with an empty table → done high in the cycle after edge S+10; hit_mask=0.
- Defaults; cars 0..9 written valid; checker model asserts collision only for carIndex=3; start → carIndex steps 0..9 on ISSUE edges; done after S+30; hit_mask=0x0008; any_hit=1.
- Only cars 2 and 7 valid; model collides both; CHECK_LAT=3 → done after S+18 (2×5 + 8×1); hit_mask=0x0084.
- With busy=1: write car 0 at x=55 and pulse start → write dropped, second start ignored. After done, a rescan shows carX=original value for carIndex=0.
- rst asserted on the second WAIT cycle of car 4 → next cycle busy=0, hit_mask=0, no done pulse, table valid bits cleared.
- With COLLISION_SCAN_EARLY_EXIT_EN, collisions on cars 3 and 5 → done after S+12; hit_mask=0x0008. Without the macro, the same stimulus gives hit_mask=0x0028.
